pkt_page_alloc: RTL and testbench
=================================

// Module: pkt_page_alloc
// PURPOSE
// Parametrised packet-to-page allocator between the receive parser and the packet buffer.
// Prefetches free pages and writes packet words into page lines. It links pages into a list,
// reports committed packets (start, end) to the forwarder, and returns aborted chains to the free-page manager.
// PARAMETERS
// DW        64  packet data word width
// PG_ASZ     8  page address width
// LN_ASZ     2  line-in-page address width; lines per page = 2**LN_ASZ
// PF_DEPTH   4  prefetched/outstanding page limit (2..16)
// PORTS
// clk        in   1            clock
// reset      in   1            async active-high reset
// crx_srdy/crx_drdy  in/out  1 packet word handshake
// crx_data   in   DW           packet word
// crx_eop    in   1            last word of packet
// crx_commit in   1            valid with eop: keep packet
// crx_abort  in   1            valid with eop: drop packet (wins over commit)
// par_srdy/par_drdy  out/in 1  page request handshake
// parr_srdy/parr_drdy in/out 1 page response handshake
// parr_page  in   PG_ASZ       granted page
// lnp_srdy/lnp_drdy  out/in 1  link-next-page handshake
// lnp_cur    out  PG_ASZ       page being linked
// lnp_nxt    out  PG_ASZ       next page (don't-care when lnp_end)
// lnp_end    out  1            cur is the list tail
// pbra_srdy/pbra_drdy out/in 1 buffer write handshake
// pbra_addr  out  PG_ASZ+LN_ASZ {page,line}
// pbra_data  out  DW           write data
// a2f_srdy/a2f_drdy  out/in 1  committed packet report
// ret_srdy/ret_drdy  out/in 1  aborted chain return
// a2f_start,a2f_end,ret_start,ret_end out PG_ASZ  chain head/tail (all = start_pg/cur_pg)
// BEHAVIOUR
// - Transfer only on srdy&drdy in the same cycle. Every srdy is held until accepted. No srdy depends combinationally on its own drdy.
// - Reset: all srdy/drdy outputs 0, state IDLE, pcount/start_pg/cur_pg/line 0, prefetch FIFO and obuf empty.
//   Mid-packet reset drops the packet and its pages; the free manager re-initialises.
// - Prefetch: pcount counts requests issued minus pages popped. par_srdy = pcount<PF_DEPTH.
//   inc&dec in the same cycle leaves pcount unchanged. parr_drdy = FIFO not full; the FIFO never overflows by construction.
// - FSM:
//   IDLE: pop a page when available -> start_pg=cur_pg=page, line=0, DATA.
//   DATA: crx_drdy=obuf_ready. On a beat, write {cur_pg,line}, line++.
//     eop -> TERM, latch drop=crx_abort|!crx_commit. Else line==max -> LINK.
//     eop on the last line goes to TERM; no extra page is used.
//   LINK: lnp_srdy=page available, lnp={cur_pg,page,0}. On handshake pop, cur_pg=page, line=0, DATA.
//   TERM: lnp_srdy=1, lnp={cur_pg,x,1}. On handshake -> drop ? RETURN : REPORT.
//   REPORT: a2f_srdy=1. On handshake -> IDLE.   RETURN: ret_srdy=1. On handshake -> IDLE.
// - crx_drdy is 0 outside DATA. Line counter wraps mod 2**LN_ASZ.
// - Write path: one-entry output half-buffer; 1-cycle latency crx beat -> pbra_srdy; throughput 1 word per 2 cycles.
//   Writes precede the TERM link: all of a packet's writes have left obuf before a2f/ret asserts.
// - Packet of N words uses ceil(N/2**LN_ASZ) pages. A 1-word packet has start==end.
// STRUCTURE
// - Shared defines: page/line widths, PBR field layout, end-page encoding, FSM state codes.
// - Prefetch FIFO: instance of sd_fifo_s (width PG_ASZ, depth PF_DEPTH). Output buffer: sd_iohalf.
// - Natural sub-module: pkt_page_alloc_fsm (FSM plus page/line counters); top level holds pcount and the instances.
// TESTING (LN_ASZ=2, PF_DEPTH=4)
// - After reset, with par_drdy=1 and no responses: exactly 4 requests, then par_srdy=0. Return page 7 -> par_srdy=1 next cycle.
// - Pages 3,5 granted; 6-word packet, commit: writes addr 12..15,20,21; lnp (3,5,0),(5,x,1); a2f (3,5).
// - 4-word packet on page 9, eop on line 3: single lnp (9,x,1), no LINK, a2f (9,9).
// - 5-word packet with crx_abort=1 and crx_commit=1 on eop: lnp tail sent; ret (p0,p1); no a2f.
// - Random drdy stalls on pbra/lnp/a2f/ret and random crx_srdy: data and addresses match the scoreboard; no beat lost or duplicated.
// - Assert reset mid-packet (word 2 of 6): all srdy low asynchronously; next packet restarts on a fresh page with pcount rebuilt from 0.

Source files
------------

// File: rtl/pkt_page_alloc_pkg.sv
// Shared definitions for the packet page allocator: default widths, link-end encoding, FSM states.
// Page-buffer write address layout is {page, line}, with the page in the upper PG_ASZ bits.
package pkt_page_alloc_pkg;

    localparam int DEF_DW       = 64;
    localparam int DEF_PG_ASZ   = 8;
    localparam int DEF_LN_ASZ   = 2;
    localparam int DEF_PF_DEPTH = 4;

    localparam logic LNP_MORE = 1'b0;
    localparam logic LNP_END  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_LINK,
        ST_TERM,
        ST_REPORT,
        ST_RETURN
    } state_e;

endpackage

// File: rtl/pkt_page_alloc_fsm.sv
// Packet sequencing FSM with page/line counters: places words into pages, links pages, reports or returns chains.
// crx_drdy only in DATA with an empty write buffer; the tail link waits for that buffer to drain.
module pkt_page_alloc_fsm
    import pkt_page_alloc_pkg::*;
#(
    parameter int PG_ASZ = DEF_PG_ASZ,
    parameter int LN_ASZ = DEF_LN_ASZ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pg_vld,
    input  logic [PG_ASZ-1:0] pg_dat,
    output logic              pg_pop,
    input  logic              crx_srdy,
    output logic              crx_drdy,
    input  logic              crx_eop,
    input  logic              crx_commit,
    input  logic              crx_abort,
    input  logic              ob_rdy,
    output logic              wr_vld,
    output logic [PG_ASZ-1:0] wr_page,
    output logic [LN_ASZ-1:0] wr_line,
    output logic              lnp_srdy,
    input  logic              lnp_drdy,
    output logic [PG_ASZ-1:0] lnp_cur,
    output logic [PG_ASZ-1:0] lnp_nxt,
    output logic              lnp_end,
    output logic              a2f_srdy,
    input  logic              a2f_drdy,
    output logic              ret_srdy,
    input  logic              ret_drdy,
    output logic [PG_ASZ-1:0] chain_start,
    output logic [PG_ASZ-1:0] chain_end
);
    state_e            state_q, state_d;
    logic [PG_ASZ-1:0] start_pg_q, start_pg_d, cur_pg_q, cur_pg_d;
    logic [LN_ASZ-1:0] line_q, line_d;
    logic              drop_q, drop_d;

    assign wr_vld      = crx_srdy & crx_drdy;
    assign wr_page     = cur_pg_q;
    assign wr_line     = line_q;
    assign lnp_cur     = cur_pg_q;
    assign chain_start = start_pg_q;
    assign chain_end   = cur_pg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_pg_q <= '0;
            cur_pg_q   <= '0;
            line_q     <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_pg_q <= start_pg_d;
            cur_pg_q   <= cur_pg_d;
            line_q     <= line_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_pg_d = start_pg_q;
        cur_pg_d   = cur_pg_q;
        line_d     = line_q;
        drop_d     = drop_q;
        case (state_q)
            ST_IDLE: if (pg_vld) begin
                start_pg_d = pg_dat;
                cur_pg_d   = pg_dat;
                line_d     = '0;
                state_d    = ST_DATA;
            end
            ST_DATA: if (crx_srdy && ob_rdy) begin
                line_d = line_q + LN_ASZ'(1);
                // eop always terminates, even on the last line, so no spare page is taken
                if (crx_eop) begin
                    drop_d  = crx_abort | !crx_commit;
                    state_d = ST_TERM;
                end else if (line_q == '1) begin
                    state_d = ST_LINK;
                end
            end
            ST_LINK: if (pg_vld && lnp_drdy) begin
                cur_pg_d = pg_dat;
                line_d   = '0;
                state_d  = ST_DATA;
            end
            ST_TERM:   if (ob_rdy && lnp_drdy) state_d = drop_q ? ST_RETURN : ST_REPORT;
            ST_REPORT: if (a2f_drdy) state_d = ST_IDLE;
            ST_RETURN: if (ret_drdy) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pg_pop   = 1'b0;
        crx_drdy = 1'b0;
        lnp_srdy = 1'b0;
        lnp_nxt  = '0;
        lnp_end  = LNP_MORE;
        a2f_srdy = 1'b0;
        ret_srdy = 1'b0;
        case (state_q)
            ST_IDLE: pg_pop = pg_vld;
            ST_DATA: crx_drdy = ob_rdy;
            ST_LINK: begin
                lnp_srdy = pg_vld;
                lnp_nxt  = pg_dat;
                pg_pop   = pg_vld & lnp_drdy;
            end
            ST_TERM: begin
                lnp_srdy = ob_rdy;
                lnp_end  = LNP_END;
            end
            ST_REPORT: a2f_srdy = 1'b1;
            ST_RETURN: ret_srdy = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/sd_fifo_s.sv
// Synchronous show-ahead FIFO with srdy/drdy ports; data visible the cycle after push.
// c_drdy drops when full and p_srdy drops when empty; neither depends on the opposite port.
module sd_fifo_s #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [WIDTH-1:0] c_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [WIDTH-1:0] p_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign c_drdy = (cnt_q != CW'(DEPTH));
    assign p_srdy = (cnt_q != '0);
    assign push   = c_srdy & c_drdy;
    assign pop    = p_srdy & p_drdy;
    assign p_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (!push && pop)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= c_data;
    end

endmodule

// File: rtl/sd_iohalf.sv
// One-entry half buffer: one cycle in-to-out latency, one word per two cycles.
// c_drdy is simply "empty", so the producer side never sees the consumer's drdy combinationally.
module sd_iohalf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [WIDTH-1:0] c_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [WIDTH-1:0] p_data
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign c_drdy = !full_q;
    assign p_srdy = full_q;
    assign p_data = data_q;

    always_comb begin
        full_d = full_q ? !p_drdy : c_srdy;
        data_d = (!full_q && c_srdy) ? c_data : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pkt_page_alloc.sv
// Packet-to-page allocator: prefetches free pages, writes words to {page,line}, links pages, reports or returns chains.
// Write latency one cycle via a half buffer (1 word / 2 cycles); every srdy holds until accepted.
module pkt_page_alloc
    import pkt_page_alloc_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int PG_ASZ   = DEF_PG_ASZ,
    parameter int LN_ASZ   = DEF_LN_ASZ,
    parameter int PF_DEPTH = DEF_PF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     crx_srdy,
    output logic                     crx_drdy,
    input  logic [DW-1:0]            crx_data,
    input  logic                     crx_eop,
    input  logic                     crx_commit,
    input  logic                     crx_abort,
    output logic                     par_srdy,
    input  logic                     par_drdy,
    input  logic                     parr_srdy,
    output logic                     parr_drdy,
    input  logic [PG_ASZ-1:0]        parr_page,
    output logic                     lnp_srdy,
    input  logic                     lnp_drdy,
    output logic [PG_ASZ-1:0]        lnp_cur,
    output logic [PG_ASZ-1:0]        lnp_nxt,
    output logic                     lnp_end,
    output logic                     pbra_srdy,
    input  logic                     pbra_drdy,
    output logic [PG_ASZ+LN_ASZ-1:0] pbra_addr,
    output logic [DW-1:0]            pbra_data,
    output logic                     a2f_srdy,
    input  logic                     a2f_drdy,
    output logic [PG_ASZ-1:0]        a2f_start,
    output logic [PG_ASZ-1:0]        a2f_end,
    output logic                     ret_srdy,
    input  logic                     ret_drdy,
    output logic [PG_ASZ-1:0]        ret_start,
    output logic [PG_ASZ-1:0]        ret_end
);
    localparam int PCW = $clog2(PF_DEPTH + 1);
    localparam int OBW = PG_ASZ + LN_ASZ + DW;

    logic [PCW-1:0]    pcount_q, pcount_d;
    logic              en_q, en_d;
    logic              fifo_c_drdy, pg_vld, pg_pop;
    logic [PG_ASZ-1:0] pg_dat, wr_page, chain_start, chain_end;
    logic [LN_ASZ-1:0] wr_line;
    logic              ob_rdy, wr_vld;
    logic [OBW-1:0]    ob_pdat;

    // en_q keeps every handshake output low while reset is held and for the first cycle after
    assign par_srdy  = en_q & (pcount_q < PCW'(PF_DEPTH));
    assign parr_drdy = en_q & fifo_c_drdy;
    assign pbra_addr = ob_pdat[DW +: PG_ASZ+LN_ASZ];
    assign pbra_data = ob_pdat[DW-1:0];
    assign a2f_start = chain_start;
    assign a2f_end   = chain_end;
    assign ret_start = chain_start;
    assign ret_end   = chain_end;

    // pcount covers FIFO occupancy plus requests in flight, so the FIFO cannot overflow
    always_comb begin
        en_d     = 1'b1;
        pcount_d = pcount_q;
        case ({par_srdy & par_drdy, pg_pop})
            2'b10:   pcount_d = pcount_q + PCW'(1);
            2'b01:   pcount_d = pcount_q - PCW'(1);
            default: pcount_d = pcount_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcount_q <= '0;
            en_q     <= 1'b0;
        end else begin
            pcount_q <= pcount_d;
            en_q     <= en_d;
        end
    end

    sd_fifo_s #(.WIDTH(PG_ASZ), .DEPTH(PF_DEPTH)) u_pf_fifo (
        .clk    (clk),
        .rst    (reset),
        .c_srdy (parr_srdy & en_q),
        .c_drdy (fifo_c_drdy),
        .c_data (parr_page),
        .p_srdy (pg_vld),
        .p_drdy (pg_pop),
        .p_data (pg_dat)
    );

    sd_iohalf #(.WIDTH(OBW)) u_obuf (
        .clk    (clk),
        .rst    (reset),
        .c_srdy (wr_vld),
        .c_drdy (ob_rdy),
        .c_data ({wr_page, wr_line, crx_data}),
        .p_srdy (pbra_srdy),
        .p_drdy (pbra_drdy),
        .p_data (ob_pdat)
    );

    pkt_page_alloc_fsm #(.PG_ASZ(PG_ASZ), .LN_ASZ(LN_ASZ)) u_fsm (
        .clk         (clk),
        .rst         (reset),
        .pg_vld      (pg_vld),
        .pg_dat      (pg_dat),
        .pg_pop      (pg_pop),
        .crx_srdy    (crx_srdy),
        .crx_drdy    (crx_drdy),
        .crx_eop     (crx_eop),
        .crx_commit  (crx_commit),
        .crx_abort   (crx_abort),
        .ob_rdy      (ob_rdy),
        .wr_vld      (wr_vld),
        .wr_page     (wr_page),
        .wr_line     (wr_line),
        .lnp_srdy    (lnp_srdy),
        .lnp_drdy    (lnp_drdy),
        .lnp_cur     (lnp_cur),
        .lnp_nxt     (lnp_nxt),
        .lnp_end     (lnp_end),
        .a2f_srdy    (a2f_srdy),
        .a2f_drdy    (a2f_drdy),
        .ret_srdy    (ret_srdy),
        .ret_drdy    (ret_drdy),
        .chain_start (chain_start),
        .chain_end   (chain_end)
    );

endmodule

// File: tb/tb_pkt_page_alloc.sv
// Scoreboard bench: pages are modelled as the grant order, so word i of a packet lands on page base+i/4, line i%4.
module tb_pkt_page_alloc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        crx_srdy, crx_drdy, crx_eop, crx_commit, crx_abort;
    logic [63:0] crx_data;
    logic        par_srdy, par_drdy, parr_srdy, parr_drdy;
    logic [7:0]  parr_page;
    logic        lnp_srdy, lnp_drdy, lnp_end;
    logic [7:0]  lnp_cur, lnp_nxt;
    logic        pbra_srdy, pbra_drdy;
    logic [9:0]  pbra_addr;
    logic [63:0] pbra_data;
    logic        a2f_srdy, a2f_drdy, ret_srdy, ret_drdy;
    logic [7:0]  a2f_start, a2f_end, ret_start, ret_end;

    pkt_page_alloc #(.DW(64), .PG_ASZ(8), .LN_ASZ(2), .PF_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .crx_srdy(crx_srdy), .crx_drdy(crx_drdy), .crx_data(crx_data), .crx_eop(crx_eop),
        .crx_commit(crx_commit), .crx_abort(crx_abort),
        .par_srdy(par_srdy), .par_drdy(par_drdy),
        .parr_srdy(parr_srdy), .parr_drdy(parr_drdy), .parr_page(parr_page),
        .lnp_srdy(lnp_srdy), .lnp_drdy(lnp_drdy), .lnp_cur(lnp_cur), .lnp_nxt(lnp_nxt), .lnp_end(lnp_end),
        .pbra_srdy(pbra_srdy), .pbra_drdy(pbra_drdy), .pbra_addr(pbra_addr), .pbra_data(pbra_data),
        .a2f_srdy(a2f_srdy), .a2f_drdy(a2f_drdy), .a2f_start(a2f_start), .a2f_end(a2f_end),
        .ret_srdy(ret_srdy), .ret_drdy(ret_drdy), .ret_start(ret_start), .ret_end(ret_end)
    );

    always #5 clk = ~clk;

    typedef struct { int base; int idx; logic [63:0] data; } wr_t;
    typedef struct { int pidx; bit is_end; } ln_t;
    typedef struct { int first; int last; } ch_t;

    wr_t        wr_q[$];
    ln_t        ln_q[$];
    ch_t        a2f_q[$];
    ch_t        ret_q[$];
    logic [7:0] grants[$];
    logic [7:0] preset[$];

    int  n_cmp = 0, n_bad = 0;
    int  req_cnt = 0, inj_req = 0, inj_done = 0, next_base = 0;
    bit  resp_en = 0, rnd_mode = 0;
    logic [7:0] inj_pg = 8'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [7:0] pg_at(input int k);
        if (k >= 0 && k < grants.size()) return grants[k];
        return 8'hxx;
    endfunction

    // output monitors: pop expectations only on an actual handshake
    always @(negedge clk) begin
        wr_t we; ln_t le; ch_t ce;
        if (!reset) begin
            if (pbra_srdy && pbra_drdy) begin
                if (wr_q.size() == 0) fail("pbra_unexpected", "write with no expected word");
                else begin
                    we = wr_q.pop_front();
                    chk("pbra_addr", pbra_addr, 64'(pg_at(we.base + we.idx / 4) * 4 + we.idx % 4));
                    chk("pbra_data", pbra_data, we.data);
                end
            end
            if (lnp_srdy && lnp_drdy) begin
                if (ln_q.size() == 0) fail("lnp_unexpected", "link with no expected link");
                else begin
                    le = ln_q.pop_front();
                    chk("lnp_cur", lnp_cur, pg_at(le.pidx));
                    chk("lnp_end", lnp_end, le.is_end);
                    if (!le.is_end) chk("lnp_nxt", lnp_nxt, pg_at(le.pidx + 1));
                end
            end
            if (a2f_srdy && a2f_drdy) begin
                chk("pbra_idle_at_a2f", pbra_srdy, 0);
                if (a2f_q.size() == 0) fail("a2f_unexpected", "report with no expected packet");
                else begin
                    ce = a2f_q.pop_front();
                    chk("a2f_start", a2f_start, pg_at(ce.first));
                    chk("a2f_end", a2f_end, pg_at(ce.last));
                end
            end
            if (ret_srdy && ret_drdy) begin
                chk("pbra_idle_at_ret", pbra_srdy, 0);
                if (ret_q.size() == 0) fail("ret_unexpected", "return with no expected chain");
                else begin
                    ce = ret_q.pop_front();
                    chk("ret_start", ret_start, pg_at(ce.first));
                    chk("ret_end", ret_end, pg_at(ce.last));
                end
            end
        end
    end

    // free-page manager: counts requests, grants pages in order, records the grant order
    initial begin
        bit hs;
        int outstanding = 0;
        parr_srdy = 1'b0;
        parr_page = 8'd0;
        par_drdy  = 1'b1;
        forever begin
            @(negedge clk);
            hs = parr_srdy && parr_drdy && !reset;
            if (reset) outstanding = 0;
            else begin
                if (par_srdy && par_drdy) begin outstanding++; req_cnt++; end
                if (hs) begin grants.push_back(parr_page); outstanding--; end
            end
            @(posedge clk); #1;
            if (hs || reset) parr_srdy = 1'b0;
            if (!reset && !parr_srdy) begin
                if (inj_req != inj_done) begin
                    parr_page = inj_pg; parr_srdy = 1'b1; inj_done++;
                end else if (resp_en && outstanding > 0 && $urandom_range(0, 2) != 0) begin
                    parr_page = (preset.size() != 0) ? preset.pop_front() : 8'($urandom_range(0, 255));
                    parr_srdy = 1'b1;
                end
            end
        end
    end

    initial begin
        pbra_drdy = 1'b1; lnp_drdy = 1'b1; a2f_drdy = 1'b1; ret_drdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            pbra_drdy = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            lnp_drdy  = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            a2f_drdy  = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            ret_drdy  = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // cut > 0 stops after that many beats without an eop
    task automatic send_pkt(input int n, input bit cm, input bit ab, input int cut);
        int np = (n + 3) / 4;
        int nb = (cut > 0) ? cut : n;
        int t;
        for (int i = 0; i < nb; i++) begin
            if (rnd_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            crx_srdy = 1'b1; crx_data = {$urandom(), $urandom()};
            crx_eop = (i == n - 1); crx_commit = cm; crx_abort = ab;
            t = 0;
            forever begin
                @(negedge clk);
                if (crx_drdy) break;
                @(posedge clk); #1;
                if (++t > 500) begin
                    fail("crx_accept", "word not accepted within 500 cycles");
                    crx_srdy = 1'b0;
                    return;
                end
            end
            wr_q.push_back('{next_base, i, crx_data});
            if (i % 4 == 3 && i != n - 1) ln_q.push_back('{next_base + i / 4, 1'b0});
            @(posedge clk); #1;
            crx_srdy = 1'b0;
        end
        if (cut == 0) begin
            ln_q.push_back('{next_base + np - 1, 1'b1});
            if (ab || !cm) ret_q.push_back('{next_base, next_base + np - 1});
            else a2f_q.push_back('{next_base, next_base + np - 1});
            next_base += np;
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((wr_q.size() + ln_q.size() + a2f_q.size() + ret_q.size()) != 0 && t < 3000) begin
            @(posedge clk); t++;
        end
        if (t >= 3000) fail(name, "expected outputs still pending after 3000 cycles");
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rst_crx_drdy", crx_drdy, 0);
        chk("rst_par_srdy", par_srdy, 0);
        chk("rst_parr_drdy", parr_drdy, 0);
        chk("rst_lnp_srdy", lnp_srdy, 0);
        chk("rst_pbra_srdy", pbra_srdy, 0);
        chk("rst_a2f_srdy", a2f_srdy, 0);
        chk("rst_ret_srdy", ret_srdy, 0);
        crx_srdy = 1'b0;
        wr_q.delete(); ln_q.delete(); a2f_q.delete(); ret_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        next_base = grants.size();
    endtask

    task automatic check_prefetch(input string name);
        int r0 = req_cnt;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk({name, "_reqs"}, 64'(req_cnt - r0), 4);
        chk({name, "_par_srdy"}, par_srdy, 0);
    endtask

    initial begin
        int t;
        crx_srdy = 1'b0; crx_data = '0; crx_eop = 1'b0; crx_commit = 1'b0; crx_abort = 1'b0;
        do_reset();
        check_prefetch("prefetch");
        inj_pg = 8'd7;
        inj_req++;
        for (t = 0; t < 10; t++) begin
            @(negedge clk);
            if (par_srdy) break;
        end
        chk("par_srdy_after_return", par_srdy, 1);

        do_reset();
        preset = '{8'd3, 8'd5, 8'd9};
        resp_en = 1;
        send_pkt(6, 1, 0, 0); drain("drain_6w");
        send_pkt(4, 1, 0, 0); drain("drain_4w");
        send_pkt(5, 1, 1, 0); drain("drain_abort");
        send_pkt(3, 0, 0, 0); drain("drain_nocommit");
        send_pkt(1, 1, 0, 0); drain("drain_1w");

        rnd_mode = 1;
        for (int k = 0; k < 40; k++)
            send_pkt($urandom_range(1, 10), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 0);
        drain("drain_random");

        send_pkt(6, 1, 0, 2);
        drain("drain_partial");
        resp_en = 0;
        do_reset();
        check_prefetch("prefetch_after_reset");
        resp_en = 1;
        send_pkt(6, 1, 0, 0);
        send_pkt(9, 1, 0, 0);
        drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
